or2_gate: RTL and testbench
===========================

Name: or2_gate

Overview:
- Bitwise 2-input OR, built structurally from NAND primitives as in the rest of the NAND-to-CPU gate library.
- Primary output y is purely combinational and does not depend on the clock.
- A clocked side path provides a registered copy of y plus a saturating activity counter, for use by later sequential blocks and by verification.

Parameters:
- WIDTH, 1, bit width of a, b, y, y_q.
- CNT_W, 16, width of the activity counter hi_cnt.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- y  output  WIDTH  combinational a OR b, bitwise.
- y_q  output  WIDTH  y registered by one clk cycle.
- any_hi  output  1  combinational OR-reduction of y.
- hi_cnt  output  CNT_W  saturating count of cycles in which any_hi was 1.
- chk_err  output  1  sticky self-check error flag; see Optional Feature.

Behaviour:
- y[i] = a[i] | b[i] for every bit, zero latency, no clock required.
- Truth table per bit: 00->0, 01->1, 10->1, 11->1.
- Known 0/1 inputs must produce strictly 0/1 on y, never X or Z.
- X on one input with 1 on the other gives 1. X with 0 gives X.
- Each y bit is implemented as nand2(nand2(a,a), nand2(b,b)). No behavioural "|" on the y path.
- y is independent of rst and clk. It stays valid during reset.
- y_q: on a rising clk edge with rst=1, y_q <= 0. Otherwise y_q <= y. Latency is 1 cycle.
- any_hi = |y, combinational.
- hi_cnt: on a rising clk edge with rst=1, hi_cnt <= 0. Otherwise, if any_hi=1 and hi_cnt is not all-ones, it increments by 1.
- hi_cnt saturates at 2^CNT_W-1 and holds there. It never wraps.
- Reset asserted mid-count clears hi_cnt on that same edge. Reset has priority over increment.
- All outputs are defined from the first clk edge with rst=1. There is no handshake.

Optional Feature:
- Macro: OR2_SELF_CHECK_EN.
- When defined:
  - A behavioural reference a|b is computed in parallel and compared each clock against y.
  - chk_err is set on any mismatch and stays set until rst.
  - rst clears chk_err synchronously.
  - Simulation additionally issues $error on the mismatch.
- When undefined: chk_err is tied to 0 and no reference logic is instantiated.

Decomposition:
- Shared package gates_pkg holds:
  - default width constant GATE_W_DEF = 1;
  - counter width constant GATE_CNT_W_DEF = 16.
- One sub-module: nand2_gate (inputs a, b; output y), instantiated 3 times per bit in a generate loop.
- The registers and counter live in or2_gate itself.

Test Plan:
- Exhaustive combinational check, WIDTH=1: apply (0,0),(0,1),(1,0),(1,1) and wait 10 ns after each. Require y=0,1,1,1, compared with !==, with no clock toggling.
- Reset: rst=1 for 2 cycles with a=1, b=0. Require y=1 throughout and y_q=0, hi_cnt=0, chk_err=0 after the edges.
- Register latency: after rst deasserts, apply a=0,b=1 then a=0,b=0 on successive cycles. Require y_q to follow y one cycle later (1 then 0).
- Counter and saturation, CNT_W=2: hold a=1 for 5 cycles. Require hi_cnt 1,2,3,3,3. Assert rst mid-run and require hi_cnt=0 on the next edge.
- Multi-bit, WIDTH=8: a=0xA0, b=0x05 gives y=0x A5 with any_hi=1. a=0x00, b=0x00 gives y=0x00, any_hi=0, and hi_cnt does not increment.
- With OR2_SELF_CHECK_EN defined: run random a/b for 1000 cycles. Require chk_err stays 0.

Source files
------------

// File: rtl/gates_pkg.sv
// Shared constants for the NAND-to-CPU gate library.
package gates_pkg;

  // Default operand width for the bitwise gates.
  localparam int GATE_W_DEF     = 1;
  // Default width of the per-gate activity counters.
  localparam int GATE_CNT_W_DEF = 16;

endpackage : gates_pkg

// File: rtl/or2_gate_if.sv
// Operand/result bundle for or2_gate.
// The master drives the operands and the slave (the gate) drives every result.
interface or2_gate_if
  import gates_pkg::*;
#(
  parameter int WIDTH = GATE_W_DEF,
  parameter int CNT_W = GATE_CNT_W_DEF
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             any_hi;
  logic [CNT_W-1:0] hi_cnt;
  logic             chk_err;

  modport master (
    output a, b,
    input  y, y_q, any_hi, hi_cnt, chk_err
  );

  modport slave (
    input  a, b,
    output y, y_q, any_hi, hi_cnt, chk_err
  );

endinterface : or2_gate_if

// File: rtl/nand2_gate.sv
// 2-input NAND, the single primitive the gate library is built from.
module nand2_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a & b);

endmodule : nand2_gate

// File: rtl/or2_gate.sv
// Bitwise 2-input OR built from NAND primitives, plus a clocked side path:
// a registered copy of y and a saturating count of cycles with any y bit high.
// Optional macro OR2_SELF_CHECK_EN adds a behavioural reference and a sticky
// mismatch flag (chk_err); without it chk_err is tied to 0.
module or2_gate
  import gates_pkg::*;
#(
  parameter int WIDTH = GATE_W_DEF,
  parameter int CNT_W = GATE_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  or2_gate_if.slave bus
);

  logic [WIDTH-1:0] y_w;
  logic             any_hi_w;
  logic [WIDTH-1:0] y_reg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             chk_err_q;

  // a | b = nand(~a, ~b), with each inversion being a self-NAND. The y path
  // stays purely structural so X/Z propagate as the real gates would.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic na;
    logic nb;

    nand2_gate u_inv_a (.a(bus.a[i]), .b(bus.a[i]), .y(na));
    nand2_gate u_inv_b (.a(bus.b[i]), .b(bus.b[i]), .y(nb));
    nand2_gate u_out   (.a(na),       .b(nb),       .y(y_w[i]));
  end

  assign any_hi_w = |y_w;

  // Next counter value: count a busy cycle unless already pinned at all-ones.
  always_comb begin
    // NOTE: assign the default first so no path leaves cnt_d unassigned,
    // which would otherwise infer a latch.
    cnt_d = cnt_q;
    if (any_hi_w && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Registered copy of y and the activity counter; reset wins over counting.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      y_reg_q <= '0;
      cnt_q   <= '0;
    end else begin
      y_reg_q <= y_w;
      cnt_q   <= cnt_d;
    end
  end

`ifdef OR2_SELF_CHECK_EN
  logic [WIDTH-1:0] ref_y;

  assign ref_y = bus.a | bus.b;

  // Sticky mismatch flag between the NAND network and the behavioural model.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err_q <= 1'b0;
    end else if (y_w != ref_y) begin
      chk_err_q <= 1'b1;
    end
  end

  // Only a definite mismatch is reported; X operands yield an X compare.
  always_ff @(posedge clk) begin
    assert (rst || ((y_w != ref_y) !== 1'b1))
      else $error("or2_gate: y=%h differs from reference %h", y_w, ref_y);
  end
`else
  assign chk_err_q = 1'b0;
`endif

  assign bus.y       = y_w;
  assign bus.any_hi  = any_hi_w;
  assign bus.y_q     = y_reg_q;
  assign bus.hi_cnt  = cnt_q;
  assign bus.chk_err = chk_err_q;

endmodule : or2_gate

// File: tb/tb_or2_gate.sv
// Directed bench for or2_gate: a 1-bit instance with a 2-bit counter for the
// truth table, reset, latency and saturation, and an 8-bit instance for
// multi-bit operation. Random traffic runs when OR2_SELF_CHECK_EN is defined.
module tb_or2_gate;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst    = 1'b0;

  int checks = 0;
  int errors = 0;

  or2_gate_if #(.WIDTH(1), .CNT_W(2))  bus1 ();
  or2_gate_if #(.WIDTH(8), .CNT_W(16)) bus8 ();

  or2_gate #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  or2_gate #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  // Clock only runs once the combinational phase is over.
  always #5 clk = clk_en ? ~clk : clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus1.a = 1'b0; bus1.b = 1'b0;
    bus8.a = 8'h00; bus8.b = 8'h00;

    // Exhaustive truth table, clock stopped.
    bus1.a = 1'b0; bus1.b = 1'b0; #10; check("tt_00", 64'(bus1.y), 64'h0);
    bus1.a = 1'b0; bus1.b = 1'b1; #10; check("tt_01", 64'(bus1.y), 64'h1);
    bus1.a = 1'b1; bus1.b = 1'b0; #10; check("tt_10", 64'(bus1.y), 64'h1);
    bus1.a = 1'b1; bus1.b = 1'b1; #10; check("tt_11", 64'(bus1.y), 64'h1);

    // Reset for two edges with a=1,b=0; y must stay valid throughout.
    bus1.a = 1'b1; bus1.b = 1'b0;
    rst    = 1'b1;
    clk_en = 1'b1;
    tick(); check("rst_y_e1", 64'(bus1.y), 64'h1);
    tick(); check("rst_y_e2", 64'(bus1.y), 64'h1);
    check("rst_yq",       64'(bus1.y_q),     64'h0);
    check("rst_cnt",      64'(bus1.hi_cnt),  64'h0);
    check("rst_chk",      64'(bus1.chk_err), 64'h0);
    check("rst_yq8",      64'(bus8.y_q),     64'h0);
    check("rst_cnt8",     64'(bus8.hi_cnt),  64'h0);
    check("rst_chk8",     64'(bus8.chk_err), 64'h0);

    // One-cycle latency of y_q.
    rst = 1'b0;
    bus1.a = 1'b0; bus1.b = 1'b1;
    tick(); check("lat_yq_1", 64'(bus1.y_q), 64'h1);
    bus1.a = 1'b0; bus1.b = 1'b0;
    tick(); check("lat_yq_0", 64'(bus1.y_q), 64'h0);
    check("lat_cnt_hold", 64'(bus1.hi_cnt), 64'h1);

    // Saturation of the 2-bit counter from a fresh reset.
    rst = 1'b1;
    tick(); check("sat_rst", 64'(bus1.hi_cnt), 64'h0);
    rst = 1'b0;
    bus1.a = 1'b1;
    tick(); check("sat_c1", 64'(bus1.hi_cnt), 64'h1);
    tick(); check("sat_c2", 64'(bus1.hi_cnt), 64'h2);
    tick(); check("sat_c3", 64'(bus1.hi_cnt), 64'h3);
    tick(); check("sat_c4", 64'(bus1.hi_cnt), 64'h3);
    tick(); check("sat_c5", 64'(bus1.hi_cnt), 64'h3);
    rst = 1'b1;
    tick(); check("sat_mid_rst", 64'(bus1.hi_cnt), 64'h0);
    check("mid_rst_yq", 64'(bus1.y_q), 64'h0);
    rst = 1'b0;

    // Multi-bit operation.
    bus8.a = 8'hA0; bus8.b = 8'h05;
    #1;
    check("mb_y_a5",   64'(bus8.y),      64'hA5);
    check("mb_any_a5", 64'(bus8.any_hi), 64'h1);
    tick();
    check("mb_yq_a5",  64'(bus8.y_q),    64'hA5);
    check("mb_cnt_1",  64'(bus8.hi_cnt), 64'h1);
    bus8.a = 8'h00; bus8.b = 8'h00;
    #1;
    check("mb_y_00",   64'(bus8.y),      64'h00);
    check("mb_any_00", 64'(bus8.any_hi), 64'h0);
    tick();
    check("mb_yq_00",  64'(bus8.y_q),    64'h00);
    check("mb_cnt_hold", 64'(bus8.hi_cnt), 64'h1);
    bus8.a = 8'h3C; bus8.b = 8'hC3;
    #1;
    check("mb_y_ff",   64'(bus8.y),      64'hFF);

    // Unknown-input behaviour on the 1-bit instance.
    bus1.a = 1'bx; bus1.b = 1'b1;
    #1;
    check("x_or_1", 64'(bus1.y), 64'h1);
    bus1.a = 1'b0; bus1.b = 1'b0;
    #1;

`ifdef OR2_SELF_CHECK_EN
    // Random traffic; the NAND network must never disagree with the model.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      bus8.a = ra;
      bus8.b = rb;
      bus1.a = ra[0];
      bus1.b = rb[0];
      tick();
      if (i % 100 == 0) begin
        check("rnd_y8", 64'(bus8.y), 64'(ra | rb));
      end
    end
    check("rnd_chk1", 64'(bus1.chk_err), 64'h0);
    check("rnd_chk8", 64'(bus8.chk_err), 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_or2_gate
